gray_conv_arbiter: RTL and testbench

//  Shares one binary<->Gray conversion datapath among NREQ requesters.

---
 rtl/gray_conv_arbiter.sv | 102 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary<->Gray converter among NREQ requesters, registered response.
// Define GRAY_ARB_CNT_EN to add the txn_count port counting completed response handshakes.
module gray_conv_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_mode,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_mode
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [15:0]             txn_count
`endif
);
    localparam int IDW = $clog2(NREQ);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_p0;
    logic [IDW-1:0]   next_ptr_p0;
    logic             found_p0;
    logic             can_accept;
    logic             vld_p0;
    logic [WIDTH-1:0] sel_data_p0;
    logic [WIDTH-1:0] conv_data_p0;

    // Stage p0: pick the first valid requester at or after rr_ptr, convert its code.
    always_comb begin
        found_p0 = 1'b0;
        grant_p0 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_p0 && req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
                found_p0 = 1'b1;
                grant_p0 = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign can_accept   = !rsp_valid || rsp_ready;
    assign vld_p0       = found_p0 && can_accept && !rst;
    assign sel_data_p0  = req_data[int'(grant_p0)*WIDTH +: WIDTH];
    assign conv_data_p0 = req_mode[grant_p0] ? gray2bin(sel_data_p0) : bin2gray(sel_data_p0);
    assign next_ptr_p0  = (int'(grant_p0) == NREQ - 1) ? '0 : grant_p0 + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (vld_p0) begin
            req_ready[grant_p0] = 1'b1;
        end
    end

    // Stage p1: response register; a pop and a new grant in one cycle simply reload it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_mode  <= 1'b0;
            rr_ptr    <= '0;
        end else if (vld_p0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= conv_data_p0;
            rsp_id    <= grant_p0;
            rsp_mode  <= req_mode[grant_p0];
            rr_ptr    <= next_ptr_p0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef GRAY_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter (NREQ=4, WIDTH=4); counter checks run when GRAY_ARB_CNT_EN is defined.
module tb_gray_conv_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_mode;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [WIDTH-1:0]        rsp_data;
    logic [1:0]              rsp_id;
    logic                    rsp_mode;
`ifdef GRAY_ARB_CNT_EN
    logic [15:0]             txn_count;
`endif

    gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_mode  (rsp_mode)
`ifdef GRAY_ARB_CNT_EN
        ,
        .txn_count (txn_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [6:0] sbq[$];
    bit         sb_on  = 1'b1;
    logic [6:0] rsp_pkt;

    assign rsp_pkt = {rsp_mode, rsp_id, rsp_data};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR form of Gray decode.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [6:0] exp_pkt(input int i, input logic m, input logic [3:0] d);
        return {m, 2'(i), (m ? g2b(d) : b2g(d))};
    endfunction

    always @(negedge clk) begin
        if (!rst && sb_on && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                check_val("sb_extra", 32'(sbq.size()), 32'd1);
            end else begin
                check_val("rsp", 32'(rsp_pkt), 32'(sbq.pop_front()));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input int i, input logic m, input logic [3:0] d, input logic [3:0] e);
        bit ok;
        req_valid          = '0;
        req_mode           = '0;
        req_data           = '0;
        req_valid[i]       = 1'b1;
        req_mode[i]        = m;
        req_data[i*4 +: 4] = d;
        sbq.push_back({m, 2'(i), e});
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check_val("send_timeout", 32'(ok), 32'd1);
        req_valid = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        sbq.delete();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_mode  = '0;
        req_data  = 16'hC963;
        rsp_ready = 1'b1;
        #2;
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_pkt",   32'(rsp_pkt),   32'd0);
`ifdef GRAY_ARB_CNT_EN
        check_val("rst_cnt",   32'(txn_count), 32'd0);
`endif
        req_valid = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic conversions and one-cycle latency
        send(0, 1'b0, 4'd5, 4'b0111);
        @(negedge clk);
        check_val("lat0_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        send(2, 1'b1, 4'b1000, 4'd15);
        @(negedge clk);
        check_val("lat2_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // Round trip through both directions
        for (int b = 0; b < 16; b++) begin
            send(b % 4, 1'b0, 4'(b), b2g(4'(b)));
            send((b + 1) % 4, 1'b1, b2g(4'(b)), 4'(b));
        end
        @(posedge clk);
        #1;

        // Round robin with all requesters valid
        do_reset();
        req_data  = 16'hC963;
        req_mode  = 4'b1010;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) sbq.push_back(exp_pkt(k % 4, req_mode[k % 4], req_data[(k % 4)*4 +: 4]));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
        end
        #1 req_valid = '0;
        @(posedge clk);
        #1;

        // Backpressure holds the response and freezes arbitration
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 2; k++) sbq.push_back(exp_pkt(k, req_mode[k], req_data[k*4 +: 4]));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("bp_pre_ready", 32'(req_ready), 32'(1 << k));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_ready", 32'(req_ready), 32'd0);
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_hold",  32'(rsp_pkt),   32'(exp_pkt(1, req_mode[1], req_data[7:4])));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        for (int k = 2; k < 5; k++) sbq.push_back(exp_pkt(k % 4, req_mode[k % 4], req_data[(k % 4)*4 +: 4]));
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_post_ready", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
        end
        #1 req_valid = '0;
        @(posedge clk);
        #1;

        // Asynchronous reset discards a held response
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        check_val("ar_held", 32'(rsp_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("ar_valid", 32'(rsp_valid), 32'd0);
        check_val("ar_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        sbq.push_back(exp_pkt(0, req_mode[0], req_data[3:0]));
        @(negedge clk);
        check_val("ar_first", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;

`ifdef GRAY_ARB_CNT_EN
        do_reset();
        check_val("cnt_zero", 32'(txn_count), 32'd0);
        send(1, 1'b0, 4'd3, 4'd2);
        send(2, 1'b0, 4'd6, 4'd5);
        send(3, 1'b1, 4'd2, 4'd3);
        @(posedge clk);
        #1;
        check_val("cnt_three", 32'(txn_count), 32'd3);
        sb_on     = 1'b0;
        req_valid = 4'b1111;
        repeat (65532) @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        sb_on = 1'b1;
        check_val("cnt_ffff", 32'(txn_count), 32'hFFFF);
        send(0, 1'b0, 4'd1, 4'd1);
        @(posedge clk);
        #1;
        check_val("cnt_wrap", 32'(txn_count), 32'd0);
`endif

        check_val("sb_drain", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
